// File: rtl/stats_sched.sv
// Window scheduler for a shared statistics engine. Rotates or pins the engine's
// channel and frames measurement windows by cycle count or by an external PPS.
module stats_sched #(
  parameter int BASE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pps_in,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  input  logic       read_strobe,
  output logic [7:0] in_port,
  output logic [1:0] ch_sel,
  output logic       stats_pps,
  output logic       stats_valid
);
  typedef enum logic [2:0] {IDLE, SWITCH, ARM, COLLECT, LATCH, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic [15:0] len_q, len_d;
  logic [15:0] win_q, win_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  settle_q, settle_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [3:0]  done_q, done_d;
  logic [1:0]  ch_q, ch_d;
  logic        pps_q, pps_d;
  logic        valid_q, valid_d;
  logic [2:0]  sync_q, sync_d;

  logic       hit;
  logic [2:0] addr;
  logic       wr_ctrl, wr_lenh, wr_lenl, rd_stat;
  logic       en, rotate, ext, pps_rise;
  logic [1:0] fix_ch;
  logic [7:0] rdata;

  always_comb begin
    hit     = (port_id >= 8'(BASE)) && ((port_id - 8'(BASE)) <= 8'd4);
    addr    = 3'(port_id - 8'(BASE));
    wr_ctrl = write_strobe && hit && (addr == 3'd0);
    wr_lenh = write_strobe && hit && (addr == 3'd2);
    wr_lenl = write_strobe && hit && (addr == 3'd3);
    rd_stat = read_strobe && hit && (addr == 3'd1);
    ctrl_d  = wr_ctrl ? (out_port & 8'h1f) : ctrl_q;
    len_d   = {wr_lenh ? out_port : len_q[15:8], wr_lenl ? out_port : len_q[7:0]};
    // The FSM acts on the value being written so a disable takes effect on the write edge.
    en       = ctrl_d[0];
    rotate   = ctrl_d[1];
    fix_ch   = ctrl_d[3:2];
    ext      = ctrl_d[4];
    sync_d   = {sync_q[1:0], pps_in};
    pps_rise = sync_q[1] & ~sync_q[2];
  end

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    wcnt_d   = wcnt_q;
    ch_d     = ch_q;
    valid_d  = valid_q;
    done_d   = rd_stat ? 4'b0000 : done_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = SWITCH;
          ch_d     = fix_ch;
          settle_d = 2'd0;
        end
        SWITCH: begin
          settle_d = settle_q + 2'd1;
          if (settle_q == 2'd3) begin
            state_d = ARM;
            valid_d = 1'b0;
          end
        end
        ARM: begin
          state_d = COLLECT;
          win_d   = (len_q < 16'd4) ? 16'd4 : len_q;
          cnt_d   = 16'd1;
        end
        COLLECT: begin
          cnt_d = cnt_q + 16'd1;
          if (ext ? pps_rise : (cnt_q >= win_q)) state_d = LATCH;
        end
        LATCH: begin
          state_d = DONE;
          valid_d = 1'b1;
        end
        DONE: begin
          state_d      = SWITCH;
          done_d[ch_q] = 1'b1;
          wcnt_d       = wcnt_q + 8'd1;
          ch_d         = rotate ? ch_q + 2'd1 : fix_ch;
          // Results no longer describe the channel now shown in STATUS.
          if (ch_d != ch_q) valid_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
    pps_d = (state_d == ARM) || (state_d == LATCH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ctrl_q   <= 8'h00;
      len_q    <= 16'd1000;
      win_q    <= 16'd4;
      cnt_q    <= 16'd0;
      settle_q <= 2'd0;
      wcnt_q   <= 8'd0;
      done_q   <= 4'b0000;
      ch_q     <= 2'd0;
      pps_q    <= 1'b0;
      valid_q  <= 1'b0;
      sync_q   <= 3'b000;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      len_q    <= len_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      wcnt_q   <= wcnt_d;
      done_q   <= done_d;
      ch_q     <= ch_d;
      pps_q    <= pps_d;
      valid_q  <= valid_d;
      sync_q   <= sync_d;
    end
  end

  always_comb begin
    case (addr)
      3'd0:    rdata = ctrl_q;
      3'd1:    rdata = {valid_q, ch_q, 1'b0, done_q};
      3'd2:    rdata = len_q[15:8];
      3'd3:    rdata = len_q[7:0];
      3'd4:    rdata = wcnt_q;
      default: rdata = 8'h00;
    endcase
  end

  assign in_port     = hit ? rdata : 8'bz;
  assign ch_sel      = ch_q;
  assign stats_pps   = pps_q;
  assign stats_valid = valid_q;
endmodule

// File: doc/stats_sched.md
STATS_SCHED -- requirements
Module: stats_sched

Interface
REQ-001 SHALL have parameter BASE, default 0, giving the first of five consecutive port addresses.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst_n, input, 1 bit, reset that is synchronous and active-low.
REQ-004 SHALL have port pps_in, input, 1 bit, external asynchronous second pulse.
REQ-005 SHALL have port port_id, input, 8 bits, the port address.
REQ-006 SHALL have port out_port, input, 8 bits, the write data.
REQ-007 SHALL have port write_strobe, input, 1 bit, the one-cycle write qualifier.
REQ-008 SHALL have port read_strobe, input, 1 bit, the one-cycle read qualifier.
REQ-009 SHALL have port in_port, output, 8 bits, the read data; it is 8'bz when port_id is outside BASE..BASE+4.
REQ-010 SHALL have port ch_sel, output, 2 bits, the channel routed to the shared statistics engine.
REQ-011 SHALL have port stats_pps, output, 1 bit, the one-cycle window strobe to the statistics engine.
REQ-012 SHALL have port stats_valid, output, 1 bit, high when the engine's latched results belong to a complete window on the channel given in the status register.

Function
REQ-013 SHALL decode the register map as follows.
- BASE+0: CTRL, R/W, {3'b0, ext, fix_ch[1:0], rotate, en}.
- BASE+1: STATUS, R, {valid, cur_ch[1:0], 1'b0, done[3:0]}.
- BASE+2: LEN[15:8], R/W.
- BASE+3: LEN[7:0], R/W.
- BASE+4: WCNT, R.
REQ-014 SHALL accept a write when write_strobe=1 and port_id matches, with the register updated on the next clock edge.
REQ-015 SHALL clear the STATUS done bits on a read_strobe at BASE+1; in_port is combinational, so the pre-clear value is returned.
REQ-016 SHALL have the states IDLE, SWITCH, ARM, COLLECT, LATCH and DONE.
REQ-017 SHALL hold IDLE while en=0, and SHALL go IDLE->SWITCH when en=1, loading ch_sel with fix_ch.
REQ-018 SHALL stay in SWITCH for exactly 4 cycles (settle) and then go to ARM.
REQ-019 SHALL spend one cycle in ARM with stats_pps=1 and stats_valid=0, snapshot LEN into the window length (values below 4 treated as 4), and then go to COLLECT.
REQ-020 SHALL, when ext=0, stay in COLLECT for exactly the window length in cycles, so that ARM pulse to LATCH pulse spacing is window length + 1 cycles.
REQ-021 SHALL, when ext=1, end COLLECT on a rising edge of pps_in after a 2-flop synchroniser and edge detect, with the window length ignored.
REQ-022 SHALL spend one cycle in LATCH with stats_pps=1 and then go to DONE.
REQ-023 SHALL, in DONE (one cycle), set stats_valid=1 and done[ch_sel]=1, increment WCNT modulo 256 (255->0), and go to SWITCH.
REQ-024 SHALL select the next channel on leaving DONE.
- rotate=1: ch_sel advances by 1 modulo 4 (3->0).
- rotate=0: ch_sel takes the current fix_ch.
REQ-025 SHALL, on en written 0 in any state, go to IDLE on the next edge with no further stats_pps, leaving stats_valid, done and WCNT unchanged.
REQ-026 SHALL apply a LEN write during COLLECT to the next window only.
REQ-027 SHALL give set priority when a done-bit set and a STATUS read-clear coincide.
REQ-028 SHALL never assert stats_pps on two consecutive cycles.
REQ-029 SHALL set STATUS cur_ch equal to ch_sel.

Reset
REQ-030 SHALL, on rst_n=0 at a clock edge, go to state IDLE and set CTRL=8'h00, LEN=16'd1000, WCNT=0, done=0, ch_sel=0, stats_pps=0, stats_valid=0, and clear the pps_in synchroniser.
REQ-031 SHALL, when reset is asserted mid-window, abandon the window without emitting a LATCH pulse.

Verification
REQ-032 SHALL cover fixed channel: LEN=16, CTRL=8'h05 (fix_ch=1) -> ch_sel=1, stats_pps at ARM and 17 cycles later, STATUS=8'hA2 after DONE, WCNT=1.
REQ-033 SHALL cover rotation: LEN=4, CTRL=8'h03, run 5 windows -> done bits set 0,1,2,3,0; ch_sel wraps 3->0; WCNT=5.
REQ-034 SHALL cover minimum clamp: LEN=2 -> pulse spacing 5 cycles, identical to LEN=4.
REQ-035 SHALL cover external mode: CTRL=8'h11, pps_in pulses every 300 cycles -> LATCH within 3-4 cycles of each pps_in rise; LEN ignored.
REQ-036 SHALL cover abort: CTRL=8'h00 written mid-COLLECT -> IDLE, no further stats_pps, WCNT unchanged; then read BASE+1 with done=1 coinciding with DONE on a new run -> done bit stays set.
REQ-037 SHALL cover reset mid-window: rst_n low 1 cycle during COLLECT -> all REQ-030 values, in_port at BASE+2 reads 8'h03.
